rf_write_queue: RTL and testbench

- Write-side initiator for the 32x32 register file; drives its RegWrite/rc/dc write port.
- Merges single-cycle datapath writebacks with results from multi-cycle producers (mult/div, slow loads).
- Multi-cycle results are buffered in a small in-order queue and retired on cycles when the datapath is not writing.
- Reports pending-write hazards to control so dependent reads stall.

---
 rtl/rf_write_queue.sv | 146 ++++++++++++++
 tb/tb_rf_write_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_queue.sv
// Register-file write initiator: merges datapath writebacks with an in-order queue of multi-cycle results.
// Optional define RF_WQ_BYPASS_EN builds newest-match bypass data on fwd_a_data/fwd_b_data.
module rf_write_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              main_we,
    input  logic [4:0]        main_rc,
    input  logic [DATA_W-1:0] main_dc,
    input  logic              sec_valid,
    output logic              sec_ready,
    input  logic [4:0]        sec_rc,
    input  logic [DATA_W-1:0] sec_dc,
    output logic              RegWrite,
    output logic [4:0]        rc,
    output logic [DATA_W-1:0] dc,
    input  logic [4:0]        hz_ra,
    input  logic [4:0]        hz_rb,
    output logic              pend_a,
    output logic              pend_b,
    output logic [DATA_W-1:0] fwd_a_data,
    output logic [DATA_W-1:0] fwd_b_data
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [4:0]        q_rc [DEPTH];
    logic [DATA_W-1:0] q_dc [DEPTH];
    logic [DEPTH-1:0]  q_vld;
    logic [DEPTH-1:0]  vld_next;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;

    logic main_act;
    logic nonempty;
    logic head_vld;
    logic push;
    logic pop;

    always_comb begin
        main_act  = main_we && (main_rc != 5'd0);
        nonempty  = (count != '0);
        head_vld  = q_vld[rd_ptr];
        sec_ready = (count != (PW+1)'(DEPTH));
        push      = sec_valid && sec_ready && (sec_rc != 5'd0);
        // A killed head is dropped even while the datapath owns the write port.
        pop       = nonempty && (!head_vld || !main_act);
    end

    always_comb begin
        vld_next = q_vld;
        if (main_act) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (q_rc[i] == main_rc)
                    vld_next[i] = 1'b0;
            end
        end
        if (pop)
            vld_next[rd_ptr] = 1'b0;
        if (push)
            vld_next[wr_ptr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            q_vld  <= '0;
        end else begin
            q_vld <= vld_next;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + (PW+1)'(1);
            else if (pop && !push)
                count <= count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rc[wr_ptr] <= sec_rc;
            q_dc[wr_ptr] <= sec_dc;
        end
    end

    always_comb begin
        RegWrite = 1'b0;
        rc       = '0;
        dc       = '0;
        if (!rst) begin
            if (main_act) begin
                RegWrite = 1'b1;
                rc       = main_rc;
                dc       = main_dc;
            end else if (nonempty && head_vld) begin
                RegWrite = 1'b1;
                rc       = q_rc[rd_ptr];
                dc       = q_dc[rd_ptr];
            end
        end
    end

    always_comb begin
        pend_a = 1'b0;
        pend_b = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (q_vld[i] && (q_rc[i] == hz_ra))
                pend_a = 1'b1;
            if (q_vld[i] && (q_rc[i] == hz_rb))
                pend_b = 1'b1;
        end
        if (hz_ra == 5'd0)
            pend_a = 1'b0;
        if (hz_rb == 5'd0)
            pend_b = 1'b0;
    end

`ifdef RF_WQ_BYPASS_EN
    logic [PW-1:0] idx;

    // Walk oldest slot (wr_ptr) to newest (wr_ptr-1); the last match wins.
    always_comb begin
        fwd_a_data = '0;
        fwd_b_data = '0;
        idx        = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = wr_ptr + PW'(k);
            if (q_vld[idx] && (q_rc[idx] == hz_ra) && (hz_ra != 5'd0))
                fwd_a_data = q_dc[idx];
            if (q_vld[idx] && (q_rc[idx] == hz_rb) && (hz_rb != 5'd0))
                fwd_b_data = q_dc[idx];
        end
    end
`else
    assign fwd_a_data = '0;
    assign fwd_b_data = '0;
`endif

endmodule

// File: tb/tb_rf_write_queue.sv
// Randomized and directed bench for rf_write_queue against a queue-based reference model.
// Honours RF_WQ_BYPASS_EN for the expected forward data.
module tb_rf_write_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        main_we = 1'b0;
    logic [4:0]  main_rc = '0;
    logic [31:0] main_dc = '0;
    logic        sec_valid = 1'b0;
    logic        sec_ready;
    logic [4:0]  sec_rc = '0;
    logic [31:0] sec_dc = '0;
    logic        RegWrite;
    logic [4:0]  rc;
    logic [31:0] dc;
    logic [4:0]  hz_ra = '0;
    logic [4:0]  hz_rb = '0;
    logic        pend_a;
    logic        pend_b;
    logic [31:0] fwd_a_data;
    logic [31:0] fwd_b_data;

    rf_write_queue #(.DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .main_we(main_we), .main_rc(main_rc), .main_dc(main_dc),
        .sec_valid(sec_valid), .sec_ready(sec_ready), .sec_rc(sec_rc), .sec_dc(sec_dc),
        .RegWrite(RegWrite), .rc(rc), .dc(dc),
        .hz_ra(hz_ra), .hz_rb(hz_rb), .pend_a(pend_a), .pend_b(pend_b),
        .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rc;
        logic [31:0] dc;
        bit          v;
    } ent_t;

    ent_t mq[$];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic        obs_we;
    logic [4:0]  obs_rc;
    logic [31:0] obs_dc;
    logic        obs_rdy;
    logic        obs_pa;
    logic [31:0] obs_fa;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void lookup(input logic [4:0] h, output bit hit, output logic [31:0] data);
        hit  = 1'b0;
        data = '0;
        foreach (mq[i]) begin
            if (mq[i].v && mq[i].rc == h && h != 5'd0) begin
                hit = 1'b1;
`ifdef RF_WQ_BYPASS_EN
                data = mq[i].dc;
`endif
            end
        end
    endfunction

    // One clock: drive inputs, compare all outputs to the model, then advance the model.
    task automatic step(input logic we, input logic [4:0] mrc, input logic [31:0] mdc,
                        input logic sv, input logic [4:0] src, input logic [31:0] sdc,
                        input logic [4:0] ha, input logic [4:0] hb);
        bit          mact, rdy, hit_a, hit_b, pop, push;
        logic        e_we;
        logic [4:0]  e_rc;
        logic [31:0] e_dc, f_a, f_b;
        ent_t        ne;
        @(negedge clk);
        main_we = we; main_rc = mrc; main_dc = mdc;
        sec_valid = sv; sec_rc = src; sec_dc = sdc;
        hz_ra = ha; hz_rb = hb;
        #2;
        mact = we && (mrc != 5'd0);
        rdy  = (mq.size() != DEPTH);
        e_we = 1'b0; e_rc = '0; e_dc = '0;
        if (mact) begin
            e_we = 1'b1; e_rc = mrc; e_dc = mdc;
        end else if (mq.size() > 0 && mq[0].v) begin
            e_we = 1'b1; e_rc = mq[0].rc; e_dc = mq[0].dc;
        end
        lookup(ha, hit_a, f_a);
        lookup(hb, hit_b, f_b);
        check("regwrite", 32'(RegWrite), 32'(e_we));
        check("rc", 32'(rc), 32'(e_rc));
        check("dc", dc, e_dc);
        check("sec_ready", 32'(sec_ready), 32'(rdy));
        check("pend_a", 32'(pend_a), 32'(hit_a));
        check("pend_b", 32'(pend_b), 32'(hit_b));
        check("fwd_a", fwd_a_data, f_a);
        check("fwd_b", fwd_b_data, f_b);
        obs_we = RegWrite; obs_rc = rc; obs_dc = dc;
        obs_rdy = sec_ready; obs_pa = pend_a; obs_fa = fwd_a_data;
        @(posedge clk);
        pop  = (mq.size() > 0) && (!mq[0].v || !mact);
        push = sv && rdy && (src != 5'd0);
        if (mact)
            foreach (mq[i]) if (mq[i].rc == mrc) mq[i].v = 1'b0;
        if (pop)
            void'(mq.pop_front());
        if (push) begin
            ne.rc = src; ne.dc = sdc; ne.v = 1'b1;
            mq.push_back(ne);
        end
    endtask

    task automatic idle(input logic [4:0] ha);
        step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, ha, 5'd0);
    endtask

    initial begin
        main_we = 1'b1; main_rc = 5'd9; main_dc = 32'hDEAD_BEEF;
        #2;
        check("rst_regwrite", 32'(RegWrite), 32'd0);
        check("rst_ready", 32'(sec_ready), 32'd1);
        check("rst_pend", 32'({pend_a, pend_b}), 32'd0);
        check("rst_fwd", fwd_a_data | fwd_b_data, 32'd0);
        @(negedge clk); main_we = 1'b0;
        @(negedge clk); rst = 1'b0;

        // single push, retired one cycle later
        step(1'b0, 5'd0, '0, 1'b1, 5'd5, 32'hA5A5_A5A5, 5'd0, 5'd0);
        check("tp1_no_passthru", 32'(obs_we), 32'd0);
        idle(5'd0);
        check("tp1_we", 32'(obs_we), 32'd1);
        check("tp1_rc", 32'(obs_rc), 32'd5);
        check("tp1_dc", obs_dc, 32'hA5A5_A5A5);
        idle(5'd0);
        check("tp1_after", 32'(obs_we), 32'd0);

        // fill while datapath holds the port, then drain in order
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 5'd9, 32'h99, 1'b1, 5'(i), 32'(i * 16), 5'd0, 5'd0);
            check("tp2_main_rc", 32'(obs_rc), 32'd9);
        end
        step(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, '0, 5'd0, 5'd0);
        check("tp2_full", 32'(obs_rdy), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            idle(5'd0);
            check("tp2_drain_rc", 32'(obs_rc), 32'(i));
            check("tp2_drain_we", 32'(obs_we), 32'd1);
        end
        idle(5'd0);
        check("tp2_ready_back", 32'(obs_rdy), 32'd1);

        // kill of a queued write by a newer datapath write
        step(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'h11, 5'd7, 5'd0);
        step(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, '0, 5'd7, 5'd0);
        check("tp3_dc", obs_dc, 32'h22);
        check("tp3_pend_before", 32'(obs_pa), 32'd1);
        idle(5'd7);
        check("tp3_pend_after", 32'(obs_pa), 32'd0);
        check("tp3_no_stale", 32'(obs_we), 32'd0);

        // push to r0 is absorbed
        step(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'h55, 5'd0, 5'd0);
        check("tp4_ready", 32'(obs_rdy), 32'd1);
        idle(5'd0);
        check("tp4_no_write", 32'(obs_we), 32'd0);

        // duplicate destinations: newest forwarded
        step(1'b1, 5'd9, 32'h9, 1'b1, 5'd3, 32'h1, 5'd0, 5'd0);
        step(1'b1, 5'd9, 32'h9, 1'b1, 5'd3, 32'h2, 5'd0, 5'd0);
        step(1'b1, 5'd9, 32'h9, 1'b1, 5'd6, 32'h6, 5'd3, 5'd6);
        check("tp5_pend", 32'(obs_pa), 32'd1);
`ifdef RF_WQ_BYPASS_EN
        check("tp5_fwd", obs_fa, 32'h2);
`else
        check("tp5_fwd", obs_fa, 32'h0);
`endif

        // asynchronous reset with three entries queued
        @(negedge clk);
        main_we = 1'b0; sec_valid = 1'b0; hz_ra = 5'd3; hz_rb = 5'd6;
        #1;
        check("pre_rst_we", 32'(RegWrite), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_we", 32'(RegWrite), 32'd0);
        check("arst_ready", 32'(sec_ready), 32'd1);
        check("arst_pend", 32'({pend_a, pend_b}), 32'd0);
        mq.delete();
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(5'd3);
            check("arst_no_stale", 32'(obs_we), 32'd0);
        end

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
